// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared stall-vector layout, priority masks and controller state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_stall_ctrl_pkg;

  localparam int STALL_W       = 7;
  localparam int STALL_PC      = 0;
  localparam int STALL_IFID    = 1;
  localparam int STALL_IDEX    = 2;
  localparam int STALL_EXMEM   = 3;
  localparam int STALL_FLUSH   = 5;
  localparam int STALL_MEMBUSY = 6;

  localparam logic [STALL_W-1:0] MASK_MEM = 7'b0001111;
  localparam logic [STALL_W-1:0] MASK_EX  = 7'b0000111;
  localparam logic [STALL_W-1:0] MASK_ID  = 7'b0000011;
  localparam logic [STALL_W-1:0] MASK_IF  = 7'b0000001;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  typedef struct packed {
    logic mem;
    logic ex;
    logic id;
    logic fetch;
  } stall_req_t;

  // Deepest requesting stage wins; it also holds every stage in front of it.
  function automatic logic [STALL_W-1:0] stall_mask(input stall_req_t req);
    logic [STALL_W-1:0] m;
    m = '0;
    if (req.mem) begin
      m = MASK_MEM;
      m[STALL_MEMBUSY] = STOP;
    end else if (req.ex) begin
      m = MASK_EX;
    end else if (req.id) begin
      m = MASK_ID;
    end else if (req.fetch) begin
      m = MASK_IF;
    end
    return m;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_watchdog.sv
// Stall watchdog: saturating run counter of consecutive stalled cycles plus sticky timeout flag.
// Latency: flag rises on the edge that brings the run counter to LIMIT.
// Backpressure: none; observes the stall indication only.
module pipe_stall_ctrl_watchdog
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stalled,
  output logic timeout
);

  localparam logic [15:0] LIMIT_C = 16'(LIMIT);

  logic [15:0] run_cnt;
  logic [15:0] run_nxt;

  always_comb begin
    run_nxt = '0;
    if (stalled) begin
      run_nxt = (run_cnt == LIMIT_C) ? run_cnt : run_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt <= '0;
      timeout <= NO_STOP;
    end else begin
      run_cnt <= run_nxt;
      if (run_nxt == LIMIT_C) begin
        timeout <= STOP;
      end
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: stall vector, redirect, fetch drain, counters.
// Latency: stall/pc_redirect/new_pc combinational; fetch_discard, counters and timeout registered.
// Backpressure: stall requests hold all upstream stages; a branch blocked by EX/MEM stalls is retried by EX.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int WDOG_LIMIT = 1024,
  parameter int CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_if,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               stallreq_mem,
  input  logic               branch_taken_ex,
  input  logic [31:0]        branch_target_ex,
  output logic [STALL_W-1:0] stall,
  output logic               pc_redirect,
  output logic [31:0]        new_pc,
  output logic               fetch_discard,
  output logic               stall_timeout,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   flush_count
);

  stall_req_t req;
  logic       flush;
  logic       stall_any;
  state_t     state_q;
  state_t     state_d;

  assign req   = '{mem: stallreq_mem, ex: stallreq_ex, id: stallreq_id, fetch: stallreq_if};
  assign flush = ~rst & branch_taken_ex & ~stallreq_mem & ~stallreq_ex;

  always_comb begin
    stall       = stall_mask(req);
    pc_redirect = NO_STOP;
    new_pc      = '0;
    // Flush beats ID/IF holds: the younger instructions are being discarded anyway.
    if (flush) begin
      stall[STALL_IDEX:STALL_PC] = '0;
      stall[STALL_FLUSH]         = STOP;
      pc_redirect                = STOP;
      new_pc                     = branch_target_ex;
    end
    if (rst) begin
      stall       = '0;
      pc_redirect = NO_STOP;
      new_pc      = '0;
    end
  end

  assign stall_any = |stall[STALL_EXMEM:STALL_PC];

  // DRAIN covers a fetch issued before the flush that has not yet returned.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (flush && stallreq_if) state_d = ST_DRAIN;
      ST_DRAIN: if (!flush && !stallreq_if) state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign fetch_discard = (state_q == ST_DRAIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_any) stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush)     flush_count  <= flush_count + CNT_W'(1);
    end
  end

  pipe_stall_ctrl_watchdog #(
    .LIMIT (WDOG_LIMIT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .stalled (stall_any),
    .timeout (stall_timeout)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: vector table for the combinational stall/redirect logic, then
// hand sequences for fetch drain, reset mid-drain and the watchdog.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        branch_taken_ex;
  logic [31:0] branch_target_ex;
  logic [6:0]  stall;
  logic        pc_redirect;
  logic [31:0] new_pc;
  logic        fetch_discard;
  logic        stall_timeout;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(
    .WDOG_LIMIT (8),
    .CNT_W      (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_if      (stallreq_if),
    .stallreq_id      (stallreq_id),
    .stallreq_ex      (stallreq_ex),
    .stallreq_mem     (stallreq_mem),
    .branch_taken_ex  (branch_taken_ex),
    .branch_target_ex (branch_target_ex),
    .stall            (stall),
    .pc_redirect      (pc_redirect),
    .new_pc           (new_pc),
    .fetch_discard    (fetch_discard),
    .stall_timeout    (stall_timeout),
    .stall_cycles     (stall_cycles),
    .flush_count      (flush_count)
  );

  // req packs {mem, ex, id, if, branch_taken}
  typedef struct {
    logic [4:0]  req;
    logic [31:0] tgt;
    logic [6:0]  es;
    logic        er;
    logic [31:0] ep;
  } vec_t;

  typedef struct {
    logic [6:0]  stall;
    logic        redir;
    logic [31:0] pc;
    logic        chk_pc;
    logic        fd;
    logic        to;
  } exp_t;

  localparam int NV = 13;
  vec_t        tbl[NV];
  exp_t        sb_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] m_sc   = '0;
  logic [31:0] m_fc   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, queue expectation, sample mid-cycle, compare, advance.
  task automatic cycle(input logic r, input logic [4:0] req, input logic [31:0] tgt,
                       input logic [6:0] es, input logic er, input logic [31:0] ep,
                       input logic efd, input logic eto);
    exp_t e;
    rst = r;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if, branch_taken_ex} = req;
    branch_target_ex = tgt;
    e = '{stall: es, redir: er, pc: ep, chk_pc: (er | r), fd: efd, to: eto};
    sb_q.push_back(e);
    #2;
    e = sb_q.pop_front();
    check("stall", {25'd0, stall}, {25'd0, e.stall});
    check("pc_redirect", {31'd0, pc_redirect}, {31'd0, e.redir});
    if (e.chk_pc) check("new_pc", new_pc, e.pc);
    check("fetch_discard", {31'd0, fetch_discard}, {31'd0, e.fd});
    check("stall_timeout", {31'd0, stall_timeout}, {31'd0, e.to});
    check("stall_cycles", stall_cycles, m_sc);
    check("flush_count", flush_count, m_fc);
    if (r) begin
      m_sc = '0;
      m_fc = '0;
    end else begin
      m_sc = m_sc + {31'd0, |es[3:0]};
      m_fc = m_fc + {31'd0, er};
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{5'b00000, 32'h0,         7'b0000000, 1'b0, 32'h0};
    tbl[1]  = '{5'b00100, 32'h0,         7'b0000011, 1'b0, 32'h0};
    tbl[2]  = '{5'b00010, 32'h0,         7'b0000001, 1'b0, 32'h0};
    tbl[3]  = '{5'b01110, 32'h0,         7'b0000111, 1'b0, 32'h0};
    tbl[4]  = '{5'b10100, 32'h0,         7'b1001111, 1'b0, 32'h0};
    tbl[5]  = '{5'b11111, 32'h0000_5000, 7'b1001111, 1'b0, 32'h0};
    tbl[6]  = '{5'b00101, 32'h0000_1040, 7'b0100000, 1'b1, 32'h0000_1040};
    tbl[7]  = '{5'b00000, 32'h0,         7'b0000000, 1'b0, 32'h0};
    tbl[8]  = '{5'b01001, 32'h0000_2000, 7'b0000111, 1'b0, 32'h0};
    tbl[9]  = '{5'b00001, 32'h0000_2000, 7'b0100000, 1'b1, 32'h0000_2000};
    tbl[10] = '{5'b10010, 32'h0,         7'b1001111, 1'b0, 32'h0};
    tbl[11] = '{5'b00001, 32'hDEAD_BEEC, 7'b0100000, 1'b1, 32'hDEAD_BEEC};
    tbl[12] = '{5'b00000, 32'h0,         7'b0000000, 1'b0, 32'h0};

    rst = 1'b1;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if, branch_taken_ex} = 5'b11111;
    branch_target_ex = 32'hFFFF_FFFC;
    @(posedge clk);
    #1;

    // Reset forces combinational outputs low whatever the requests say.
    cycle(1'b1, 5'b11111, 32'hFFFF_FFFC, 7'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 5'b00101, 32'h0000_1234, 7'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      cycle(1'b0, tbl[i].req, tbl[i].tgt, tbl[i].es, tbl[i].er, tbl[i].ep, 1'b0, 1'b0);
    end

    // Flush with a fetch in flight, re-flush during the drain, then release.
    cycle(1'b0, 5'b00011, 32'h0000_3000, 7'b0100000, 1'b1, 32'h0000_3000, 1'b0, 1'b0);
    cycle(1'b0, 5'b00010, 32'h0,         7'b0000001, 1'b0, 32'h0,         1'b1, 1'b0);
    cycle(1'b0, 5'b00011, 32'h0000_3100, 7'b0100000, 1'b1, 32'h0000_3100, 1'b1, 1'b0);
    cycle(1'b0, 5'b00010, 32'h0,         7'b0000001, 1'b0, 32'h0,         1'b1, 1'b0);
    cycle(1'b0, 5'b00000, 32'h0,         7'b0000000, 1'b0, 32'h0,         1'b1, 1'b0);
    cycle(1'b0, 5'b00000, 32'h0,         7'b0000000, 1'b0, 32'h0,         1'b0, 1'b0);

    // Reset arriving mid-drain.
    cycle(1'b0, 5'b00011, 32'h0000_4000, 7'b0100000, 1'b1, 32'h0000_4000, 1'b0, 1'b0);
    cycle(1'b0, 5'b00010, 32'h0,         7'b0000001, 1'b0, 32'h0,         1'b1, 1'b0);
    cycle(1'b1, 5'b10011, 32'h0000_4100, 7'b0000000, 1'b0, 32'h0,         1'b1, 1'b0);
    cycle(1'b0, 5'b00010, 32'h0,         7'b0000001, 1'b0, 32'h0,         1'b0, 1'b0);
    cycle(1'b0, 5'b00000, 32'h0,         7'b0000000, 1'b0, 32'h0,         1'b0, 1'b0);

    // Watchdog: EX stall for 10 cycles trips the flag after the 8th.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 5'b01000, 32'h0, 7'b0000111, 1'b0, 32'h0, 1'b0, (i >= 8));
    end
    cycle(1'b0, 5'b00000, 32'h0, 7'b0000000, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 5'b00000, 32'h0, 7'b0000000, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 5'b01000, 32'h0, 7'b0000000, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 5'b00000, 32'h0, 7'b0000000, 1'b0, 32'h0, 1'b0, 1'b0);

    // A short stall run after reset must not re-arm the flag.
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 5'b00100, 32'h0, 7'b0000011, 1'b0, 32'h0, 1'b0, 1'b0);
    end
    cycle(1'b0, 5'b00000, 32'h0, 7'b0000000, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 5'b00000, 32'h0, 7'b0000000, 1'b0, 32'h0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
